// File: rtl/uart_rx_oversampler_if.sv
// -----------------------------------------------------------------------------
// uart_rx_oversampler_if
// Bundles the serial-side inputs, the frame configuration and the parallel
// result of the UART receiver.
//   baud_clk     : 16x baud square wave (driven by the baud generator)
//   rx           : serial line, idle high
//   parity_en    : frame carries a parity bit
//   parity_type  : 0 = even, 1 = odd
//   stop_bits    : 0 = one stop bit, 1 = two stop bits
//   rx_data      : last received data word
//   rx_done      : one-clock pulse per completed frame
//   parity_error : parity mismatch on the last frame
//   frame_error  : a sampled stop bit was 0 on the last frame
//   rx_busy      : receiver is inside a frame
// master = side that drives the line/config (baud generator / host / bench)
// slave  = the receiver itself
// -----------------------------------------------------------------------------
interface uart_rx_oversampler_if #(
    parameter int DATA_BITS = 8
);
    logic                 baud_clk;
    logic                 rx;
    logic                 parity_en;
    logic                 parity_type;
    logic                 stop_bits;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_done;
    logic                 parity_error;
    logic                 frame_error;
    logic                 rx_busy;

    modport master (
        output baud_clk, rx, parity_en, parity_type, stop_bits,
        input  rx_data, rx_done, parity_error, frame_error, rx_busy
    );

    modport slave (
        input  baud_clk, rx, parity_en, parity_type, stop_bits,
        output rx_data, rx_done, parity_error, frame_error, rx_busy
    );
endinterface

// File: rtl/uart_rx_oversampler.sv
// -----------------------------------------------------------------------------
// uart_rx_oversampler
// UART receiver running in the system clock domain. A rising edge of the 16x
// baud square wave produces a one-clock tick; all frame processing advances on
// ticks only. Bits are sampled once at their centre (no majority vote),
// LSB first, with optional parity and one or two stop bits.
// Ports:
//   clock    : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : uart_rx_oversampler_if.slave (serial input, config, results)
// -----------------------------------------------------------------------------
module uart_rx_oversampler #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    uart_rx_oversampler_if.slave    bus
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] MID_CNT  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ---------------------------------------------------------------- input
    logic [1:0] r_rx_sync;     // [0] metastability flop, [1] usable rx_s
    logic       r_baud_q;
    logic       w_rx;
    logic       w_tick;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_sync <= 2'b11;
            r_baud_q  <= 1'b0;
        end else begin
            r_rx_sync <= {r_rx_sync[0], bus.rx};
            r_baud_q  <= bus.baud_clk;
        end
    end

    assign w_rx   = r_rx_sync[1];
    assign w_tick = bus.baud_clk & ~r_baud_q;

    // ---------------------------------------------------------------- state
    state_t               r_state,        w_state_next;
    logic [CW-1:0]        r_cnt,          w_cnt_next;
    logic [BW-1:0]        r_bit_cnt,      w_bit_cnt_next;
    logic [DATA_BITS-1:0] r_shift,        w_shift_next;
    logic                 r_perr,         w_perr_next;
    logic                 r_ferr,         w_ferr_next;
    logic                 r_par_en,       w_par_en_next;
    logic                 r_par_type,     w_par_type_next;
    logic                 r_stop2,        w_stop2_next;
    logic                 r_stop_idx,     w_stop_idx_next;
    logic [DATA_BITS-1:0] r_rx_data,      w_rx_data_next;
    logic                 r_parity_error, w_parity_error_next;
    logic                 r_frame_error,  w_frame_error_next;
    logic                 r_rx_done,      w_rx_done_next;
    logic                 w_ferr_acc;

    // Error accumulator including the stop sample taken on this tick, so the
    // final stop bit is reflected in the output on the same clock.
    assign w_ferr_acc = r_ferr | ~w_rx;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_bit_cnt      <= '0;
            r_shift        <= '0;
            r_perr         <= 1'b0;
            r_ferr         <= 1'b0;
            r_par_en       <= 1'b0;
            r_par_type     <= 1'b0;
            r_stop2        <= 1'b0;
            r_stop_idx     <= 1'b0;
            r_rx_data      <= '0;
            r_parity_error <= 1'b0;
            r_frame_error  <= 1'b0;
            r_rx_done      <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_bit_cnt      <= w_bit_cnt_next;
            r_shift        <= w_shift_next;
            r_perr         <= w_perr_next;
            r_ferr         <= w_ferr_next;
            r_par_en       <= w_par_en_next;
            r_par_type     <= w_par_type_next;
            r_stop2        <= w_stop2_next;
            r_stop_idx     <= w_stop_idx_next;
            r_rx_data      <= w_rx_data_next;
            r_parity_error <= w_parity_error_next;
            r_frame_error  <= w_frame_error_next;
            r_rx_done      <= w_rx_done_next;
        end
    end

    always_comb begin
        w_state_next        = r_state;
        w_cnt_next          = r_cnt;
        w_bit_cnt_next      = r_bit_cnt;
        w_shift_next        = r_shift;
        w_perr_next         = r_perr;
        w_ferr_next         = r_ferr;
        w_par_en_next       = r_par_en;
        w_par_type_next     = r_par_type;
        w_stop2_next        = r_stop2;
        w_stop_idx_next     = r_stop_idx;
        w_rx_data_next      = r_rx_data;
        w_parity_error_next = r_parity_error;
        w_frame_error_next  = r_frame_error;
        w_rx_done_next      = 1'b0;   // pulse: counted in clocks, not ticks

        if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rx) begin
                        // Configuration is frozen for the whole frame here.
                        w_state_next    = S_START;
                        w_cnt_next      = '0;
                        w_perr_next     = 1'b0;
                        w_ferr_next     = 1'b0;
                        w_par_en_next   = bus.parity_en;
                        w_par_type_next = bus.parity_type;
                        w_stop2_next    = bus.stop_bits;
                    end
                end

                S_START: begin
                    w_cnt_next = r_cnt + CW'(1);
                    if (r_cnt == MID_CNT) begin
                        if (!w_rx) begin
                            // Centre of the start bit: realign the counter so
                            // every following sample lands mid-bit.
                            w_state_next   = S_DATA;
                            w_cnt_next     = '0;
                            w_bit_cnt_next = '0;
                        end else begin
                            w_state_next = S_IDLE;   // glitch, not a start bit
                        end
                    end
                end

                S_DATA: begin
                    w_cnt_next = r_cnt + CW'(1);
                    if (r_cnt == LAST_CNT) begin
                        // Right shift: first bit received ends up at bit 0.
                        w_shift_next = {w_rx, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == LAST_BIT) begin
                            w_state_next    = r_par_en ? S_PARITY : S_STOP;
                            w_stop_idx_next = 1'b0;
                        end else begin
                            w_bit_cnt_next = r_bit_cnt + BW'(1);
                        end
                    end
                end

                S_PARITY: begin
                    w_cnt_next = r_cnt + CW'(1);
                    if (r_cnt == LAST_CNT) begin
                        w_perr_next  = (^r_shift) ^ w_rx ^ r_par_type;
                        w_state_next = S_STOP;
                    end
                end

                S_STOP: begin
                    w_cnt_next = r_cnt + CW'(1);
                    if (r_cnt == LAST_CNT) begin
                        w_ferr_next = w_ferr_acc;
                        if (!r_stop2 || r_stop_idx) begin
                            // Leaving at mid-stop lets a back-to-back start
                            // edge be caught on the very next falling edge.
                            w_rx_data_next      = r_shift;
                            w_parity_error_next = r_perr;
                            w_frame_error_next  = w_ferr_acc;
                            w_rx_done_next      = 1'b1;
                            w_state_next        = S_IDLE;
                        end else begin
                            w_stop_idx_next = 1'b1;
                        end
                    end
                end

                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    assign bus.rx_data      = r_rx_data;
    assign bus.rx_done      = r_rx_done;
    assign bus.parity_error = r_parity_error;
    assign bus.frame_error  = r_frame_error;
    assign bus.rx_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_oversampler
// Drives serial frames bit by bit (128 clocks per bit, baud_clk toggling every
// 4 clocks) and compares each received frame against the frame the bench
// itself intended to send, with parity/framing outcome derived from the
// UART rules (ones count, stop bit levels).
// -----------------------------------------------------------------------------
module tb_uart_rx_oversampler;
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic baud_r  = 1'b0;
    int   bdiv    = 0;

    int checks   = 0;
    int failures = 0;

    uart_rx_oversampler_if #(.DATA_BITS(8)) bus_if ();

    uart_rx_oversampler #(
        .DATA_BITS (8),
        .OVERSAMPLE(16)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus_if)
    );

    always #5 clock = ~clock;

    // baud square wave: toggles every 4 clocks -> one rising edge per 8 clocks
    always @(posedge clock) begin
        if (bdiv == 3) begin
            bdiv   <= 0;
            baud_r <= ~baud_r;
        end else begin
            bdiv <= bdiv + 1;
        end
    end
    assign bus_if.baud_clk = baud_r;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } frame_t;

    frame_t got_q[$];
    frame_t exp_q[$];
    frame_t last_exp = '{8'h00, 1'b0, 1'b0};
    int     done_run = 0;
    int     max_run  = 0;

    // Capture every completed frame and the longest rx_done high run.
    always @(negedge clock) begin
        if (bus_if.rx_done === 1'b1) begin
            got_q.push_back('{bus_if.rx_data, bus_if.parity_error, bus_if.frame_error});
            done_run <= done_run + 1;
            if (done_run + 1 > max_run) max_run <= done_run + 1;
        end else begin
            done_run <= 0;
        end
    end

    task automatic bit_time(input logic v);
        @(negedge clock) bus_if.rx = v;
        repeat (127) @(negedge clock);
    endtask

    // Sends one frame and pushes the expected outcome to exp_q.
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                              input logic pflip, input logic two, input logic s1,
                              input logic s2, input int gap, output logic busy_ok);
        logic   pbit;
        frame_t e;
        bus_if.parity_en   = pen;
        bus_if.parity_type = ptyp;
        bus_if.stop_bits   = two;
        busy_ok = 1'b1;
        // correct parity bit makes the total ones count match the type
        pbit = logic'((($countones(d) + int'(ptyp)) % 2)) ^ pflip;
        bit_time(1'b0);
        busy_ok &= bus_if.rx_busy;
        for (int i = 0; i < 8; i++) begin
            bit_time(d[i]);
            busy_ok &= bus_if.rx_busy;
        end
        if (pen) begin
            bit_time(pbit);
            busy_ok &= bus_if.rx_busy;
        end
        if (two) begin
            bit_time(s1);
            busy_ok &= bus_if.rx_busy;
            bit_time(s2);
        end else begin
            bit_time(s1);
        end
        e.data = d;
        e.perr = pen && ((($countones(d) + int'(pbit)) % 2) != int'(ptyp));
        e.ferr = !s1 || (two && !s2);
        exp_q.push_back(e);
        $display("tx frame data=%02h pen=%0d ptype=%0d pbit=%0d stop2=%0d s1=%0d s2=%0d",
                 d, pen, ptyp, pbit, two, s1, s2);
        if (gap > 0) begin
            @(negedge clock) bus_if.rx = 1'b1;
            repeat (gap - 1) @(negedge clock);
        end
    endtask

    task automatic test_reset;
        checks++;
        if (bus_if.rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%02h exp=00", bus_if.rx_data); end
        checks++;
        if (bus_if.rx_done !== 1'b0) begin failures++; $display("FAIL reset_rx_done got=%b exp=0", bus_if.rx_done); end
        checks++;
        if (bus_if.parity_error !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b exp=0", bus_if.parity_error); end
        checks++;
        if (bus_if.frame_error !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", bus_if.frame_error); end
        checks++;
        if (bus_if.rx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus_if.rx_busy); end
        $display("reset state checked");
    endtask

    task automatic test_8n1;
        logic bo;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64, bo);
        checks++;
        if (bo !== 1'b1) begin failures++; $display("FAIL 8n1_busy_in_frame got=%b exp=1", bo); end
        checks++;
        if (bus_if.rx_busy !== 1'b0) begin failures++; $display("FAIL 8n1_busy_after got=%b exp=0", bus_if.rx_busy); end
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL 8n1_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            frame_t g = got_q.pop_front();
            frame_t e = exp_q.pop_front();
            last_exp = e;
            checks++;
            if (g.data !== e.data || g.perr !== e.perr || g.ferr !== e.ferr) begin
                failures++;
                $display("FAIL 8n1_frame got=%02h/%b/%b exp=%02h/%b/%b", g.data, g.perr, g.ferr, e.data, e.perr, e.ferr);
            end
        end
        checks++;
        if (max_run !== 1) begin failures++; $display("FAIL 8n1_done_width got=%0d exp=1", max_run); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_false_start;
        @(negedge clock) bus_if.rx = 1'b0;
        repeat (23) @(negedge clock);
        checks++;
        if (bus_if.rx_busy !== 1'b1) begin failures++; $display("FAIL fs_busy_during got=%b exp=1", bus_if.rx_busy); end
        repeat (9) @(negedge clock);
        bus_if.rx = 1'b1;
        repeat (128) @(negedge clock);
        checks++;
        if (got_q.size() != 0) begin failures++; $display("FAIL fs_no_done got=%0d exp=0", got_q.size()); end
        checks++;
        if (bus_if.rx_busy !== 1'b0) begin failures++; $display("FAIL fs_busy_after got=%b exp=0", bus_if.rx_busy); end
        checks++;
        if (bus_if.rx_data !== last_exp.data || bus_if.parity_error !== last_exp.perr ||
            bus_if.frame_error !== last_exp.ferr) begin
            failures++;
            $display("FAIL fs_flags_held got=%02h/%b/%b exp=%02h/%b/%b", bus_if.rx_data,
                     bus_if.parity_error, bus_if.frame_error, last_exp.data, last_exp.perr, last_exp.ferr);
        end
        $display("false start checked");
        got_q.delete();
    endtask

    task automatic test_parity;
        logic bo;
        send_frame(8'h37, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64, bo);
        send_frame(8'h37, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64, bo);
        send_frame(8'hC4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64, bo);
        send_frame(8'hC4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64, bo);
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL par_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            frame_t g = got_q.pop_front();
            frame_t e = exp_q.pop_front();
            last_exp = e;
            checks++;
            if (g.data !== e.data || g.perr !== e.perr || g.ferr !== e.ferr) begin
                failures++;
                $display("FAIL par_frame got=%02h/%b/%b exp=%02h/%b/%b", g.data, g.perr, g.ferr, e.data, e.perr, e.ferr);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_frame_error;
        logic bo;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 256, bo);
        checks++;
        if (bus_if.frame_error !== 1'b1) begin failures++; $display("FAIL fe_flag_set got=%b exp=1", bus_if.frame_error); end
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64, bo);
        checks++;
        if (bus_if.frame_error !== 1'b0) begin failures++; $display("FAIL fe_flag_clear got=%b exp=0", bus_if.frame_error); end
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL fe_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            frame_t g = got_q.pop_front();
            frame_t e = exp_q.pop_front();
            last_exp = e;
            checks++;
            if (g.data !== e.data || g.perr !== e.perr || g.ferr !== e.ferr) begin
                failures++;
                $display("FAIL fe_frame got=%02h/%b/%b exp=%02h/%b/%b", g.data, g.perr, g.ferr, e.data, e.perr, e.ferr);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back;
        logic bo;
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 256, bo);
        checks++;
        if (bo !== 1'b1) begin failures++; $display("FAIL b2b_busy_two_stop got=%b exp=1", bo); end
        send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, bo);
        send_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64, bo);
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            frame_t g = got_q.pop_front();
            frame_t e = exp_q.pop_front();
            last_exp = e;
            checks++;
            if (g.data !== e.data || g.perr !== e.perr || g.ferr !== e.ferr) begin
                failures++;
                $display("FAIL b2b_frame got=%02h/%b/%b exp=%02h/%b/%b", g.data, g.perr, g.ferr, e.data, e.perr, e.ferr);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_frame;
        logic       bo;
        logic [7:0] d = 8'hC3;
        // leave both error flags and a non-zero word on the outputs first
        send_frame(8'h81, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 256, bo);
        checks++;
        if (bus_if.rx_data !== 8'h81 || bus_if.parity_error !== 1'b1 || bus_if.frame_error !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_state got=%02h/%b/%b exp=81/1/1", bus_if.rx_data, bus_if.parity_error, bus_if.frame_error);
        end
        got_q.delete(); exp_q.delete();
        bus_if.parity_en = 1'b0; bus_if.stop_bits = 1'b0;
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(d[i]);
        @(negedge clock) bus_if.rx = d[4];
        repeat (60) @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus_if.rx_data !== 8'h00 || bus_if.rx_done !== 1'b0 || bus_if.parity_error !== 1'b0 ||
            bus_if.frame_error !== 1'b0 || bus_if.rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_async_clear got=%02h/%b/%b/%b/%b exp=00/0/0/0/0", bus_if.rx_data,
                     bus_if.rx_done, bus_if.parity_error, bus_if.frame_error, bus_if.rx_busy);
        end
        repeat (4) @(negedge clock);
        bus_if.rx = 1'b1;
        reset_n = 1'b1;
        repeat (1500) @(negedge clock);
        checks++;
        if (got_q.size() != 0) begin failures++; $display("FAIL rst_aborted_done got=%0d exp=0", got_q.size()); end
        got_q.delete();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64, bo);
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rst_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            frame_t g = got_q.pop_front();
            frame_t e = exp_q.pop_front();
            last_exp = e;
            checks++;
            if (g.data !== e.data || g.perr !== e.perr || g.ferr !== e.ferr) begin
                failures++;
                $display("FAIL rst_frame got=%02h/%b/%b exp=%02h/%b/%b", g.data, g.perr, g.ferr, e.data, e.perr, e.ferr);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random;
        logic bo;
        for (int n = 0; n < 16; n++) begin
            logic [7:0] d     = 8'($urandom_range(0, 255));
            logic       pen   = 1'($urandom_range(0, 1));
            logic       ptyp  = 1'($urandom_range(0, 1));
            logic       pflip = ($urandom_range(0, 3) == 0);
            logic       two   = 1'($urandom_range(0, 1));
            logic       s1    = ($urandom_range(0, 4) != 0);
            logic       s2    = ($urandom_range(0, 4) != 0);
            int         gap;
            if (!s1 || (two && !s2)) gap = 256;
            else if (n == 15)        gap = 128;
            else                     gap = ($urandom_range(0, 1) == 0) ? 0 : 50;
            send_frame(d, pen, ptyp, pflip, two, s1, s2, gap, bo);
            checks++;
            if (bo !== 1'b1) begin failures++; $display("FAIL rnd_busy frame=%0d got=%b exp=1", n, bo); end
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rnd_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            frame_t g = got_q.pop_front();
            frame_t e = exp_q.pop_front();
            last_exp = e;
            checks++;
            if (g.data !== e.data || g.perr !== e.perr || g.ferr !== e.ferr) begin
                failures++;
                $display("FAIL rnd_frame got=%02h/%b/%b exp=%02h/%b/%b", g.data, g.perr, g.ferr, e.data, e.perr, e.ferr);
            end
        end
        checks++;
        if (max_run !== 1) begin failures++; $display("FAIL rnd_done_width got=%0d exp=1", max_run); end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        bus_if.rx          = 1'b1;
        bus_if.parity_en   = 1'b0;
        bus_if.parity_type = 1'b0;
        bus_if.stop_bits   = 1'b0;
        reset_n            = 1'b0;
        repeat (5) @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);

        test_reset();
        test_8n1();
        test_false_start();
        test_parity();
        test_frame_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
